// File: rtl/shift_pkg.sv
// Shared types for the execute-stage shift unit.
// Op encodings, widths and the result entry bundle.
package shift_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int TAG_W   = 3;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  // Encoded as {out_valid, skid_valid}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  tag;
    logic              zero;
    logic              carry;
  } entry_t;

endpackage

// File: rtl/shift_exec_stage_if.sv
// Request/result handshake bundle of the shift stage.
// slave is the stage view, master the issue/writeback view.
interface shift_exec_stage_if;
  import shift_pkg::*;

  logic               in_valid;
  logic               in_ready;
  op_e                in_op;
  logic [DATA_W-1:0]  in_a;
  logic [SHAMT_W-1:0] in_shamt;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_result;
  logic [TAG_W-1:0]   out_tag;
  logic               out_zero;
  logic               out_carry;

  modport master (
    output in_valid, in_op, in_a,
    output in_shamt, in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result,
    input  out_tag, out_zero, out_carry
  );

  modport slave (
    input  in_valid, in_op, in_a,
    input  in_shamt, in_tag,
    input  out_ready,
    output in_ready,
    output out_valid, out_result,
    output out_tag, out_zero, out_carry
  );

endinterface

// File: rtl/shift_core.sv
// Combinational SLL/SRL/SRA/ROL with carry-out.
// A zero shift amount passes the operand through with carry 0.
module shift_core
  import shift_pkg::*;
(
  input  op_e                i_op,
  input  logic [DATA_W-1:0]  i_a,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [DATA_W-1:0]  o_result,
  output logic               o_carry
);

  logic [SHAMT_W-1:0] w_inv;
  logic [SHAMT_W-1:0] w_dec;
  logic               w_nz;

  // DATA_W - s wraps naturally in SHAMT_W bits
  assign w_inv = '0 - i_shamt;
  assign w_dec = i_shamt - 1'b1;
  assign w_nz  = |i_shamt;

  always_comb begin
    o_result = i_a;
    o_carry  = 1'b0;
    if (w_nz) begin
      unique case (1'b1)
        (i_op == OP_SLL): begin
          o_result = i_a << i_shamt;
          o_carry  = i_a[w_inv];
        end
        (i_op == OP_SRL): begin
          o_result = i_a >> i_shamt;
          o_carry  = i_a[w_dec];
        end
        (i_op == OP_SRA): begin
          o_result = $signed(i_a) >>> i_shamt;
          o_carry  = i_a[w_dec];
        end
        (i_op == OP_ROL): begin
          o_result = (i_a << i_shamt) | (i_a >> w_inv);
          o_carry  = i_a[w_inv];
        end
        default: begin
          o_result = i_a;
          o_carry  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Execute-stage shift unit: 1-cycle latency, 2-entry skid output,
// in_ready taken straight from the skid-valid state bit.
module shift_exec_stage
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  shift_exec_stage_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  entry_t            r_out;
  entry_t            r_skid;
  entry_t            w_new;
  logic [DATA_W-1:0] w_res;
  logic              w_carry;
  logic              w_accept;
  logic              w_pop;
  logic              w_ld_new;
  logic              w_ld_fwd;
  logic              w_ld_skid;

  shift_core u_core (
    .i_op     (bus.in_op),
    .i_a      (bus.in_a),
    .i_shamt  (bus.in_shamt),
    .o_result (w_res),
    .o_carry  (w_carry)
  );

  assign w_new.result = w_res;
  assign w_new.tag    = bus.in_tag;
  assign w_new.zero   = (w_res == '0);
  assign w_new.carry  = w_carry;

  assign bus.in_ready   = ~r_state[0];
  assign bus.out_valid  = r_state[1];
  assign bus.out_result = r_out.result;
  assign bus.out_tag    = r_out.tag;
  assign bus.out_zero   = r_out.zero;
  assign bus.out_carry  = r_out.carry;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_pop    = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_accept && !w_pop)      w_state_nxt = ST_FULL;
          else if (!w_accept && w_pop) w_state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_ld_new  = 1'b0;
    w_ld_fwd  = 1'b0;
    w_ld_skid = 1'b0;
    if (!flush) begin
      case (r_state)
        ST_EMPTY: w_ld_new = w_accept;
        ST_ONE: begin
          w_ld_new  = w_accept & w_pop;
          w_ld_skid = w_accept & ~w_pop;
        end
        ST_FULL:  w_ld_fwd = w_pop;
        default: ;
      endcase
    end
  end

  // Data regs are not cleared by flush; only the valid bits matter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_new)      r_out <= w_new;
      else if (w_ld_fwd) r_out <= r_skid;
      if (w_ld_skid)     r_skid <= w_new;
    end
  end

endmodule
